// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer.
//   - keypad codes for the operator, clear and equals keys
//   - operator encoding presented to the arithmetic unit
//   - sequencer state encoding (also exposed on the debug port)
//   - small helpers to classify key codes
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQU = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_OP  = 2'd1,
    S_B   = 2'd2,
    S_REQ = 2'd3
  } calc_state_e;

  function automatic logic key_is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic key_is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys are contiguous from KEY_ADD, so the offset is the encoding.
  function automatic calc_op_e key_to_op(input logic [3:0] k);
    logic [3:0] ofs;
    ofs = k - KEY_ADD;
    return calc_op_e'(ofs[1:0]);
  endfunction

  // 10**n as a constant function, used for the operand width check.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Key input and arithmetic-request bundle of the calculator key sequencer.
//   key_valid/key_code : one-cycle key strobe with its 4-bit keypad code
//   req_valid/req_ready: request to the arithmetic unit
//   operand_a/operand_b/operator: request payload
// Handshake: req_valid rises when '#' completes operand B; while it is high
// operand_a, operand_b and operator are stable; the request is consumed on
// the first rising edge where req_valid && req_ready are both high.
// Modports: slave = the sequencer (consumes keys, issues the request);
//           master = the environment (presses keys, accepts the request).
interface calc_key_sequencer_if #(
  parameter int DATA_W = 14
);
  logic              key_valid;
  logic [3:0]        key_code;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [1:0]        operator;

  modport slave (
    input  key_valid, key_code, req_ready,
    output req_valid, operand_a, operand_b, operator
  );

  modport master (
    output key_valid, key_code, req_ready,
    input  req_valid, operand_a, operand_b, operator
  );
endinterface

// File: rtl/calc_digit_accum.sv
// One decimal operand register with its digit counter.
//   clk, rst        : clock, asynchronous active-high reset
//   clear_i         : zero value and count (highest priority)
//   load_first_i    : start a new operand with digit_i, count = 1
//   accumulate_i    : value = value*10 + digit_i while count < MAX_DIGITS
//   digit_i         : decimal digit 0..9
//   value_o/count_o : operand value and digits entered
//   sat_o           : digit limit reached; further accumulates are dropped
module calc_digit_accum #(
  parameter int MAX_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_first_i,
  input  logic              accumulate_i,
  input  logic [3:0]        digit_i,
  output logic [DATA_W-1:0] value_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              sat_o
);

  logic [DATA_W-1:0] value_q, value_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign sat_o = (count_q >= CNT_W'(MAX_DIGITS));

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clear_i) begin
      value_d = '0;
      count_d = '0;
    end else if (load_first_i) begin
      value_d = DATA_W'(digit_i);
      count_d = CNT_W'(1);
    end else if (accumulate_i && !sat_o) begin
      // x*10 as shift-and-add; result wraps at DATA_W bits.
      value_d = (value_q << 3) + (value_q << 1) + DATA_W'(digit_i);
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value_o = value_q;
  assign count_o = count_q;

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: turns keypad strobes into an arithmetic request.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : key input and request handshake (slave side)
//   display     : operand being entered (A in S_A, B otherwise)
//   digit_count : digits entered in the current operand
//   overflow    : sticky, a digit was dropped at the digit limit
//   state_o     : current sequencer state (debug)
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int  MAX_DIGITS = 4,
  parameter int  DATA_W     = 14,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_key_sequencer_if.slave  bus,
  output logic [DATA_W-1:0]    display,
  output logic [CNT_W-1:0]     digit_count,
  output logic                 overflow,
  output calc_state_e          state_o
);

  localparam longint unsigned DEC_MAX = pow10(MAX_DIGITS) - 1;

  if (DATA_W < 63 && ((64'd1 << DATA_W) <= DEC_MAX)) begin : g_width_check
    $error("calc_key_sequencer: DATA_W too narrow for MAX_DIGITS decimal digits");
  end

  calc_state_e       state_q, state_d;
  calc_op_e          op_q, op_d;
  logic              req_q, req_d;
  logic              ovf_q, ovf_d;

  logic              clr;
  logic              a_acc;
  logic              b_load, b_acc;
  logic [DATA_W-1:0] a_val, b_val;
  logic [CNT_W-1:0]  a_cnt, b_cnt;
  logic              a_sat, b_sat;
  logic              key_clr;
  logic              handshake;

  assign key_clr   = bus.key_valid && (bus.key_code == KEY_CLR);
  assign handshake = (state_q == S_REQ) && req_q && bus.req_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    req_d   = req_q;
    ovf_d   = ovf_q;
    clr     = 1'b0;
    a_acc   = 1'b0;
    b_load  = 1'b0;
    b_acc   = 1'b0;

    // Clear key wins over a concurrent handshake; both reset the sequencer.
    if (key_clr || handshake) begin
      state_d = S_A;
      op_d    = OP_ADD;
      req_d   = 1'b0;
      ovf_d   = 1'b0;
      clr     = 1'b1;
    end else if (bus.key_valid) begin
      unique case (state_q)
        S_A: begin
          if (key_is_digit(bus.key_code)) begin
            if (a_sat) ovf_d = 1'b1;
            else       a_acc = 1'b1;
          end else if (key_is_op(bus.key_code)) begin
            op_d    = key_to_op(bus.key_code);
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (key_is_op(bus.key_code)) begin
            op_d = key_to_op(bus.key_code);
          end else if (key_is_digit(bus.key_code)) begin
            b_load  = 1'b1;
            state_d = S_B;
          end
        end
        S_B: begin
          if (key_is_digit(bus.key_code)) begin
            if (b_sat) ovf_d = 1'b1;
            else       b_acc = 1'b1;
          end else if (bus.key_code == KEY_EQU) begin
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
        S_REQ: ; // everything but clear is dropped
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      op_q    <= OP_ADD;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
    end
  end

  calc_digit_accum #(
    .MAX_DIGITS (MAX_DIGITS),
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W)
  ) u_acc_a (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clr),
    .load_first_i (1'b0),
    .accumulate_i (a_acc),
    .digit_i      (bus.key_code),
    .value_o      (a_val),
    .count_o      (a_cnt),
    .sat_o        (a_sat)
  );

  calc_digit_accum #(
    .MAX_DIGITS (MAX_DIGITS),
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W)
  ) u_acc_b (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clr),
    .load_first_i (b_load),
    .accumulate_i (b_acc),
    .digit_i      (bus.key_code),
    .value_o      (b_val),
    .count_o      (b_cnt),
    .sat_o        (b_sat)
  );

  // Operand A keeps its count after the operator key; S_OP reports zero
  // digits because operand B has not been started yet.
  always_comb begin
    digit_count = b_cnt;
    unique case (state_q)
      S_A:     digit_count = a_cnt;
      S_OP:    digit_count = '0;
      default: digit_count = b_cnt;
    endcase
  end

  assign display       = (state_q == S_A) ? a_val : b_val;
  assign overflow      = ovf_q;
  assign state_o       = state_q;
  assign bus.req_valid = req_q;
  assign bus.operand_a = a_val;
  assign bus.operand_b = b_val;
  assign bus.operator  = op_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;
  import calc_pkg::*;

  localparam int MAX_DIGITS = 4;
  localparam int DATA_W     = 14;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_key_sequencer_if #(.DATA_W(DATA_W)) bus ();
  logic [DATA_W-1:0] display;
  logic [CNT_W-1:0]  digit_count;
  logic              overflow;
  calc_state_e       state_o;

  calc_key_sequencer #(
    .MAX_DIGITS (MAX_DIGITS),
    .DATA_W     (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .display     (display),
    .digit_count (digit_count),
    .overflow    (overflow),
    .state_o     (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int a, input int b, input logic [1:0] op,
                           input logic req, input int disp, input int cnt, input logic ovf,
                           input logic [1:0] st);
    check({tag, ".operand_a"},   32'(bus.operand_a), 32'(a));
    check({tag, ".operand_b"},   32'(bus.operand_b), 32'(b));
    check({tag, ".operator"},    32'(bus.operator),  32'(op));
    check({tag, ".req_valid"},   32'(bus.req_valid), 32'(req));
    check({tag, ".display"},     32'(display),       32'(disp));
    check({tag, ".digit_count"}, 32'(digit_count),   32'(cnt));
    check({tag, ".overflow"},    32'(overflow),      32'(ovf));
    check({tag, ".state"},       32'(state_o),       32'(st));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] key;
    logic       ready;
    int         a;
    int         b;
    logic [1:0] op;
    logic       req;
    int         disp;
    int         cnt;
    logic       ovf;
    logic [1:0] st;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [3:0] key, input logic ready, input int a, input int b,
                              input logic [1:0] op, input logic req, input int disp, input int cnt,
                              input logic ovf, input logic [1:0] st);
    vec_t v;
    v.key = key; v.ready = ready; v.a = a; v.b = b; v.op = op; v.req = req;
    v.disp = disp; v.cnt = cnt; v.ovf = ovf; v.st = st;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic press(input logic [3:0] key, input logic ready);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = key;
    bus.req_ready = ready;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.req_ready = 1'b0;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      press(vecs[i].key, vecs[i].ready);
      check_all($sformatf("row%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].req,
                vecs[i].disp, vecs[i].cnt, vecs[i].ovf, vecs[i].st);
    end
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    //                 key     rdy  a     b   op     req   disp  cnt ovf   state
    vecs[0]  = mk(4'h1,   1'b0, 1,    0,  2'b00, 1'b0, 1,    1,  1'b0, S_A);
    vecs[1]  = mk(4'h2,   1'b0, 12,   0,  2'b00, 1'b0, 12,   2,  1'b0, S_A);
    vecs[2]  = mk(KEY_ADD, 1'b0, 12,  0,  2'b00, 1'b0, 0,    0,  1'b0, S_OP);
    vecs[3]  = mk(4'h3,   1'b0, 12,   3,  2'b00, 1'b0, 3,    1,  1'b0, S_B);
    vecs[4]  = mk(KEY_EQU, 1'b0, 12,  3,  2'b00, 1'b1, 3,    1,  1'b0, S_REQ);
    vecs[5]  = mk(4'h9,   1'b0, 9,    0,  2'b00, 1'b0, 9,    1,  1'b0, S_A);
    vecs[6]  = mk(4'h8,   1'b0, 98,   0,  2'b00, 1'b0, 98,   2,  1'b0, S_A);
    vecs[7]  = mk(4'h7,   1'b0, 987,  0,  2'b00, 1'b0, 987,  3,  1'b0, S_A);
    vecs[8]  = mk(4'h6,   1'b0, 9876, 0,  2'b00, 1'b0, 9876, 4,  1'b0, S_A);
    vecs[9]  = mk(4'h5,   1'b0, 9876, 0,  2'b00, 1'b0, 9876, 4,  1'b1, S_A);
    vecs[10] = mk(KEY_MUL, 1'b0, 9876, 0, 2'b10, 1'b0, 0,    0,  1'b1, S_OP);
    vecs[11] = mk(4'h2,   1'b0, 9876, 2,  2'b10, 1'b0, 2,    1,  1'b1, S_B);
    vecs[12] = mk(KEY_EQU, 1'b0, 9876, 2, 2'b10, 1'b1, 2,    1,  1'b1, S_REQ);
    vecs[13] = mk(4'h4,   1'b0, 4,    0,  2'b00, 1'b0, 4,    1,  1'b0, S_A);
    vecs[14] = mk(KEY_ADD, 1'b0, 4,   0,  2'b00, 1'b0, 0,    0,  1'b0, S_OP);
    vecs[15] = mk(KEY_DIV, 1'b0, 4,   0,  2'b11, 1'b0, 0,    0,  1'b0, S_OP);
    vecs[16] = mk(4'h7,   1'b0, 4,    7,  2'b11, 1'b0, 7,    1,  1'b0, S_B);
    vecs[17] = mk(KEY_SUB, 1'b0, 4,   7,  2'b11, 1'b0, 7,    1,  1'b0, S_B);
    vecs[18] = mk(KEY_CLR, 1'b0, 0,   0,  2'b00, 1'b0, 0,    0,  1'b0, S_A);
    vecs[19] = mk(KEY_EQU, 1'b0, 0,   0,  2'b00, 1'b0, 0,    0,  1'b0, S_A);
    vecs[20] = mk(KEY_ADD, 1'b0, 0,   0,  2'b00, 1'b0, 0,    0,  1'b0, S_OP);
    vecs[21] = mk(KEY_EQU, 1'b0, 0,   0,  2'b00, 1'b0, 0,    0,  1'b0, S_OP);
    vecs[22] = mk(4'h5,   1'b0, 0,    5,  2'b00, 1'b0, 5,    1,  1'b0, S_B);
    vecs[23] = mk(KEY_EQU, 1'b0, 0,   5,  2'b00, 1'b1, 5,    1,  1'b0, S_REQ);
    vecs[24] = mk(4'h3,   1'b0, 0,    5,  2'b00, 1'b1, 5,    1,  1'b0, S_REQ);
    vecs[25] = mk(KEY_CLR, 1'b1, 0,   0,  2'b00, 1'b0, 0,    0,  1'b0, S_A);

    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.req_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_all("reset", 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, S_A);
    rst = 1'b0;
    @(negedge clk);
    check_all("after_reset", 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, S_A);

    // 12 + 3, then hold the request with req_ready low.
    apply_rows(0, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_all($sformatf("hold%0d", c), 12, 3, 2'b00, 1'b1, 3, 1, 1'b0, S_REQ);
    end
    pulse_ready();
    check_all("handshake1", 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, S_A);

    // Digit limit and sticky overflow, cleared by the handshake.
    apply_rows(5, 12);
    pulse_ready();
    check_all("handshake2", 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, S_A);

    // Last operator wins, no chaining in S_B, clear key.
    apply_rows(13, 18);

    // '#' ignored in S_A/S_OP, empty operand A, keys dropped in S_REQ,
    // clear together with req_ready aborts the request.
    apply_rows(19, 25);

    // Asynchronous reset mid-cycle while in S_B with display 42.
    press(4'h1, 1'b0);
    press(KEY_ADD, 1'b0);
    press(4'h4, 1'b0);
    press(4'h2, 1'b0);
    check_all("pre_rst", 1, 42, 2'b00, 1'b0, 42, 2, 1'b0, S_B);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, S_A);
    @(negedge clk);
    rst = 1'b0;

    // Idle key_valid holds state.
    press(4'h7, 1'b0);
    press(KEY_SUB, 1'b0);
    repeat (10) @(negedge clk);
    check_all("idle", 7, 0, 2'b01, 1'b0, 0, 0, 1'b0, S_OP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Sequential successor to the combinational key classifier in the calculator front end.
- Consumes one 4-bit keypad code per strobe, accumulates decimal digits into operand A and operand B, and latches the operator.
- Issues a valid/ready request to the arithmetic unit on '#'; exposes the operand being entered for the display path.
- Parametrised in digit count and operand width.

Parameters:
- MAX_DIGITS, 4, maximum decimal digits per operand.
- DATA_W, 14, operand width; must satisfy 2^DATA_W > 10^MAX_DIGITS - 1 (elaboration-time check).
- CNT_W, $clog2(MAX_DIGITS+1), width of the digit counter (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is sampled only when high.
- key_code  in  4  0x0-0x9 digit; 0xA add, 0xB sub, 0xC mul, 0xD div; 0xE '*' clear; 0xF '#' equals.
- req_ready  in  1  arithmetic unit accepts the request.
- req_valid  out  1  request pending.
- operand_a  out  DATA_W  latched first operand.
- operand_b  out  DATA_W  latched second operand.
- operator  out  2  00 add, 01 sub, 10 mul, 11 div.
- display  out  DATA_W  operand currently being entered: A in S_A, B in S_OP/S_B/S_REQ.
- digit_count  out  CNT_W  digits entered in the current operand.
- overflow  out  1  sticky: a digit was dropped because the limit was reached.

Behaviour:
- Reset (asynchronous, immediate): state S_A; all outputs 0.
- Key processing: all updates are registered one cycle after the key_valid edge. With key_valid low, state is held.
- Clear (0xE) has priority in every state, including S_REQ:
  - state goes to S_A; operands, operator, count, overflow and req_valid go to 0.
  - An outstanding request is aborted, even if req_ready is high in the same cycle.
- S_A, digit d:
  - If digit_count < MAX_DIGITS: operand_a <= operand_a*10 + d (computed as (x<<3)+(x<<1)+d, truncated to DATA_W); digit_count increments.
  - Otherwise the digit is ignored and overflow <= 1.
- S_A, operator key: operator latched; state goes to S_OP; digit_count <= 0. Zero digits entered is legal and gives operand A = 0. '#' is ignored.
- S_OP, operator key: replaces operator; state unchanged.
- S_OP, digit: operand_b <= d; digit_count <= 1; state goes to S_B. '#' is ignored.
- S_B, digit: same accumulate and limit rule as S_A, applied to operand_b.
- S_B, '#': req_valid <= 1; state goes to S_REQ.
- S_B, operator key: ignored (no chaining).
- S_REQ:
  - All keys except clear are ignored.
  - req_valid is held high with operand_a, operand_b and operator stable until req_valid && req_ready.
  - On that handshake cycle, the next edge performs the same clearing as the clear key.
- Simultaneous events: key_valid with clear in the same cycle as the handshake counts as a clear. Any other key in S_REQ is dropped regardless of req_ready.
- overflow is cleared only by clear, by handshake completion, or by reset.
- Reset asserted mid-operation, including during S_REQ, drops req_valid asynchronously.

Decomposition:
- Shared package calc_pkg holds:
  - key code constants KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_MUL=4'hC, KEY_DIV=4'hD, KEY_CLR=4'hE, KEY_EQU=4'hF;
  - operator encodings OP_ADD..OP_DIV;
  - state encoding S_A, S_OP, S_B, S_REQ.
- One natural sub-module, calc_digit_accum:
  - holds one operand register and its count, with inputs load_first, accumulate and clear;
  - outputs value and saturation;
  - instantiated twice, for A and B.

Test Plan:
- Reset, then keys 1,2,+(A),3,'#' -> operand_a=12, operand_b=3, operator=00, req_valid=1. With req_ready held low, outputs stay stable 5 cycles. Pulse req_ready -> next cycle all outputs 0, state S_A.
- Keys 9,8,7,6,5 (MAX_DIGITS=4) -> operand_a=9876, digit_count=4, overflow=1. Then C,2,'#', handshake -> overflow back to 0.
- Keys 4,A,D,7 -> operator=11 (last operator wins), operand_b=7. A further B key is ignored: operator stays 11.
- Keys '#' in S_A and '#' in S_OP -> req_valid stays 0. Key operator with no digits, 5, '#' -> operand_a=0, operand_b=5, req_valid=1.
- In S_REQ, key 3 -> ignored. Key '*' together with req_ready=1 -> req_valid=0, operands 0, no handshake counted.
- Assert rst asynchronously mid-cycle during S_B with display=42 -> all outputs 0 before the next clk edge. key_valid low for 10 cycles -> no change.
